// File: rtl/seg_scan_decoder_pkg.sv
// Shared seg7 definitions: digit segment codes, blank code, decode result and scan FSM states.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Ports: none.
package seg_scan_decoder_pkg;

  typedef enum logic [1:0] {
    WAIT_SEL = 2'd0,
    SETTLE   = 2'd1,
    HOLD     = 2'd2
  } scan_state_t;

  // Active-low segment patterns seg[6:0] = g..a; element i encodes hex digit i.
  localparam logic [15:0][6:0] SEG7_DIGIT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] hex;
    logic       blank;
    logic       invalid;
  } seg7_dec_t;

  // A digit is selected only when exactly one active-low anode is driven.
  function automatic logic an_sel_valid(input logic [3:0] an);
    return ($countones(~an) == 1);
  endfunction

  // Only meaningful when an_sel_valid() is true.
  function automatic logic [1:0] an_sel_index(input logic [3:0] an);
    case (an)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_decode.sv
// Combinational 7-segment pattern decoder: pattern -> {hex, blank, invalid}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: pattern = active-low seg[6:0]; dec = decoded value, blank flag, undecodable flag.
module seg7_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output seg7_dec_t  dec
);

  always_comb begin
    dec = '{hex: 4'h0, blank: 1'b0, invalid: 1'b1};
    if (pattern == SEG7_BLANK) begin
      dec.blank   = 1'b1;
      dec.invalid = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG7_DIGIT[i]) begin
        dec.hex     = 4'(i);
        dec.invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the four hex digits shown on a multiplexed 7-segment display by sniffing an/seg.
// Latency: pin change to capture = 2 + STABLE_CYCLES cycles; fourth capture to frame_stb = 1 cycle.
// Backpressure: none; inputs are sampled every cycle and a new frame simply overwrites outputs.
// Ports: clk_100mhz, rst_n (async active-low); an/seg display pins (active-low);
//        hex3..hex0, blank_mask, dp_mask, err, frame_stb (last committed frame); stale (timeout).
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [7:0] seg,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] blank_mask,
  output logic [3:0] dp_mask,
  output logic       err,
  output logic       frame_stb,
  output logic       stale
);

  localparam logic [15:0] STABLE_LIM = 16'(STABLE_CYCLES);
  localparam logic [23:0] TO_LIM     = 24'(TIMEOUT_CYCLES);

  // Pins idle high, so synchronizers and the history register reset to all ones.
  logic [3:0] an_meta, an_sync, an_prev;
  logic [7:0] seg_meta, seg_sync, seg_prev;

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      an_meta  <= '1;
      an_sync  <= '1;
      an_prev  <= '1;
      seg_meta <= '1;
      seg_sync <= '1;
      seg_prev <= '1;
    end else begin
      an_meta  <= an;
      an_sync  <= an_meta;
      an_prev  <= an_sync;
      seg_meta <= seg;
      seg_sync <= seg_meta;
      seg_prev <= seg_sync;
    end
  end

  logic       sel_valid;
  logic [1:0] sel_idx;
  logic       an_changed;
  logic       sample_changed;
  logic       stable_hit;
  logic [15:0] stable_cnt;

  assign sel_valid      = an_sel_valid(an_sync);
  assign sel_idx        = an_sel_index(an_sync);
  assign an_changed     = (an_sync != an_prev);
  assign sample_changed = an_changed || (seg_sync != seg_prev);
  // The counter holds the number of identical samples seen so far; this one makes it +1.
  assign stable_hit     = ((stable_cnt + 16'd1) == STABLE_LIM);

  // ---------------- scan FSM ----------------
  scan_state_t state, state_nxt;
  logic cnt_load, cnt_inc, capture;

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) state <= WAIT_SEL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SEL: if (sel_valid) state_nxt = SETTLE;
      SETTLE: begin
        if (sample_changed)  state_nxt = sel_valid ? SETTLE : WAIT_SEL;
        else if (stable_hit) state_nxt = HOLD;
      end
      HOLD:     if (an_changed) state_nxt = sel_valid ? SETTLE : WAIT_SEL;
      default:  state_nxt = WAIT_SEL;
    endcase
  end

  always_comb begin
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    capture  = 1'b0;
    case (state)
      WAIT_SEL: cnt_load = sel_valid;
      SETTLE: begin
        cnt_load = sample_changed && sel_valid;
        cnt_inc  = !sample_changed;
        capture  = !sample_changed && stable_hit;
      end
      HOLD:     cnt_load = an_changed && sel_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n)        stable_cnt <= '0;
    else if (cnt_load) stable_cnt <= 16'd1;
    else if (cnt_inc)  stable_cnt <= stable_cnt + 16'd1;
  end

  // ---------------- decode and shadow frame ----------------
  seg7_dec_t dec;

  seg7_decode u_seg7_decode (
    .pattern (seg_sync[6:0]),
    .dec     (dec)
  );

  logic [3:0][3:0] sh_hex;
  logic [3:0]      sh_blank, sh_dp, sh_err, seen;
  logic [3:0]      seen_nxt, sh_err_nxt;
  logic            commit;

  assign commit = &seen;

  // A commit and a capture may share an edge: clear first, then record the new capture.
  always_comb begin
    seen_nxt   = commit ? 4'h0 : seen;
    sh_err_nxt = commit ? 4'h0 : sh_err;
    if (capture) begin
      seen_nxt[sel_idx]   = 1'b1;
      sh_err_nxt[sel_idx] = dec.invalid;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      sh_hex   <= '0;
      sh_blank <= '0;
      sh_dp    <= '0;
      sh_err   <= '0;
      seen     <= '0;
    end else begin
      seen   <= seen_nxt;
      sh_err <= sh_err_nxt;
      if (capture) begin
        sh_hex[sel_idx]   <= dec.hex;
        sh_blank[sel_idx] <= dec.blank;
        sh_dp[sel_idx]    <= ~seg_sync[7];
      end
    end
  end

  // ---------------- committed outputs ----------------
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      hex3       <= '0;
      hex2       <= '0;
      hex1       <= '0;
      hex0       <= '0;
      blank_mask <= 4'hF;
      dp_mask    <= '0;
      err        <= 1'b0;
      frame_stb  <= 1'b0;
    end else begin
      frame_stb <= commit;
      if (commit) begin
        hex3       <= sh_hex[3];
        hex2       <= sh_hex[2];
        hex1       <= sh_hex[1];
        hex0       <= sh_hex[0];
        blank_mask <= sh_blank;
        dp_mask    <= sh_dp;
        err        <= |sh_err;
      end
    end
  end

  // ---------------- staleness timer ----------------
  logic [23:0] to_cnt;

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n)                to_cnt <= '0;
    else if (commit)           to_cnt <= '0;
    else if (to_cnt != TO_LIM) to_cnt <= to_cnt + 24'd1;
  end

  assign stale = (to_cnt == TO_LIM);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scan patterns, a frame-level model
// compared every cycle, plus hand-computed expectations for each scenario.
module tb_seg_scan_decoder;

  localparam int STABLE = 1000;
  localparam int TMO    = 10000;

  logic       clk_100mhz = 1'b0;
  logic       rst_n;
  logic [3:0] an;
  logic [7:0] seg;
  logic [3:0] hex3, hex2, hex1, hex0, blank_mask, dp_mask;
  logic       err, frame_stb, stale;

  always #5 clk_100mhz = ~clk_100mhz;

  seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .an         (an),
    .seg        (seg),
    .hex3       (hex3),
    .hex2       (hex2),
    .hex1       (hex1),
    .hex0       (hex0),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .err        (err),
    .frame_stb  (frame_stb),
    .stale      (stale)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames = 0;
  int last_stb_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [11:0] d1, d2;         // two-sample pin delay
  logic [3:0]  pa;
  logic [7:0]  pg;
  int          run;            // length of current run of identical, selected samples
  bit          locked;         // digit already taken since the anode last changed
  logic [3:0]  seen, sh_blank, sh_dp, sh_err;
  logic [3:0]  sh_hex [4];
  logic [3:0]  m_hex [4];
  logic [3:0]  m_blank, m_dp;
  logic        m_err, m_stb;
  int          to;

  function automatic void model_decode(input logic [6:0] p, output logic [3:0] h,
                                       output logic b, output logic e);
    h = 4'h0; b = 1'b0; e = 1'b0;
    case (p)
      7'h40: h = 4'h0;  7'h79: h = 4'h1;  7'h24: h = 4'h2;  7'h30: h = 4'h3;
      7'h19: h = 4'h4;  7'h12: h = 4'h5;  7'h02: h = 4'h6;  7'h78: h = 4'h7;
      7'h00: h = 4'h8;  7'h10: h = 4'h9;  7'h08: h = 4'hA;  7'h03: h = 4'hB;
      7'h46: h = 4'hC;  7'h21: h = 4'hD;  7'h06: h = 4'hE;  7'h0E: h = 4'hF;
      7'h7F: b = 1'b1;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_hex[k] = 4'h0;
      sh_hex[k] = 4'h0;
    end
    m_blank = 4'hF; m_dp = 4'h0; m_err = 1'b0; m_stb = 1'b0; to = 0;
    seen = 4'h0; sh_blank = 4'h0; sh_dp = 4'h0; sh_err = 4'h0;
    d1 = 12'hFFF; d2 = 12'hFFF; pa = 4'hF; pg = 8'hFF; run = 0; locked = 0;
  endtask

  task automatic model_step();
    logic [3:0] a, h;
    logic [7:0] g;
    logic       b, e;
    int         zeros, idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (seen == 4'hF) begin
      for (int k = 0; k < 4; k++) m_hex[k] = sh_hex[k];
      m_blank = sh_blank; m_dp = sh_dp; m_err = |sh_err; m_stb = 1'b1;
      seen = 4'h0; sh_err = 4'h0; to = 0;
    end else begin
      m_stb = 1'b0;
      if (to < TMO) to++;
    end
    a = d2[11:8]; g = d2[7:0];
    d2 = d1; d1 = {an, seg};
    zeros = 0; idx = 0;
    for (int k = 0; k < 4; k++) if (!a[k]) begin zeros++; idx = k; end
    if (zeros != 1) begin run = 0; locked = 0; end
    else if (a != pa) begin run = 1; locked = 0; end
    else if (!locked) begin
      if (g != pg) run = 1;
      else run++;
    end
    if (zeros == 1 && !locked && run == STABLE) begin
      model_decode(g[6:0], h, b, e);
      sh_hex[idx] = h; sh_blank[idx] = b; sh_dp[idx] = !g[7]; sh_err[idx] = e;
      seen[idx] = 1'b1; locked = 1;
    end
    pa = a; pg = g;
  endtask

  // ---------------- per-cycle compare ----------------
  logic [31:0] act_v, exp_v;

  always @(posedge clk_100mhz) begin
    cyc++;
    model_step();
    #1;
    act_v = {5'd0, hex3, hex2, hex1, hex0, blank_mask, dp_mask, err, frame_stb, stale};
    exp_v = {5'd0, m_hex[3], m_hex[2], m_hex[1], m_hex[0], m_blank, m_dp, m_err, m_stb, (to == TMO)};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_cycle %0d: got %07h expected %07h", cyc, act_v, exp_v);
    end
    if (frame_stb) begin
      frames++;
      last_stb_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a;
    seg = s;
    repeat (n) @(negedge clk_100mhz);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hex"},   {16'd0, hex3, hex2, hex1, hex0}, 32'h0);
    check({tag, "_blank"}, {28'd0, blank_mask}, 32'hF);
    check({tag, "_dp"},    {28'd0, dp_mask}, 32'h0);
    check({tag, "_err"},   {31'd0, err}, 32'h0);
    check({tag, "_stb"},   {31'd0, frame_stb}, 32'h0);
    check({tag, "_stale"}, {31'd0, stale}, 32'h0);
  endtask

  task automatic scan_1234(input int n);
    hold(4'hE, 8'hF9, n);
    hold(4'hD, 8'hA4, n);
    hold(4'hB, 8'hB0, n);
    hold(4'h7, 8'h99, n);
    hold(4'hF, 8'hFF, 20);
  endtask

  int c4;
  int stale_cyc;

  initial begin
    an = 4'hF;
    seg = 8'hFF;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk_100mhz);

    // Digits 1,2,3,4 each held 2000 cycles.
    hold(4'hE, 8'hF9, 2000);
    hold(4'hD, 8'hA4, 2000);
    hold(4'hB, 8'hB0, 2000);
    c4 = cyc;
    hold(4'h7, 8'h99, 2000);
    hold(4'hF, 8'hFF, 10);
    check("scan_frames", frames, 1);
    check("scan_hex", {hex3, hex2, hex1, hex0}, 32'h4321);
    check("scan_err", err, 0);
    check("scan_blank", blank_mask, 0);
    check("scan_dp", dp_mask, 0);
    check("scan_latency", last_stb_cyc - c4, 1003);

    // Digit 0 glitching every 500 cycles is never taken.
    for (int i = 0; i < 6; i++) hold(4'hE, (i % 2) ? 8'hA4 : 8'hF9, 500);
    hold(4'hD, 8'hA4, 1200);
    hold(4'hB, 8'hB0, 1200);
    hold(4'h7, 8'h99, 1200);
    hold(4'hF, 8'hFF, 20);
    check("glitch_no_frame", frames, 1);
    hold(4'hE, 8'hC0, 1200);
    hold(4'hF, 8'hFF, 20);
    check("glitch_then_frame", frames, 2);
    check("glitch_hex", {hex3, hex2, hex1, hex0}, 32'h4320);

    // All anodes low is no selection.
    hold(4'h0, 8'hF9, 5000);
    hold(4'hD, 8'hA4, 1200);
    hold(4'hB, 8'hB0, 1200);
    hold(4'h7, 8'h99, 1200);
    hold(4'hF, 8'hFF, 20);
    check("allsel_no_frame", frames, 2);
    hold(4'hE, 8'hF9, 1200);
    hold(4'hF, 8'hFF, 20);
    check("allsel_then_frame", frames, 3);

    // Stability boundary: 999 samples miss, exactly 1000 capture.
    hold(4'hE, 8'hF9, 999);
    hold(4'hF, 8'hFF, 5);
    hold(4'hD, 8'hA4, 1000);
    hold(4'hB, 8'hB0, 1000);
    hold(4'h7, 8'h99, 1000);
    hold(4'hF, 8'hFF, 5);
    check("bound_999_no_frame", frames, 3);
    hold(4'hE, 8'hF9, 1000);
    hold(4'hF, 8'hFF, 5);
    check("bound_1000_frame", frames, 4);

    // Blank, decimal point and undecodable patterns.
    hold(4'hB, 8'hFF, 1200);
    hold(4'hE, 8'h7F, 1200);
    hold(4'hD, 8'hAA, 1200);
    hold(4'h7, 8'h99, 1200);
    hold(4'hF, 8'hFF, 20);
    check("special_frames", frames, 5);
    check("special_blank", blank_mask, 32'h5);
    check("special_dp", dp_mask, 32'h1);
    check("special_err", err, 1);
    check("special_hex", {hex3, hex2, hex1, hex0}, 32'h4000);

    // Recapture overwrites a slot; seg change while holding is ignored.
    hold(4'hE, 8'hF9, 1200);
    hold(4'hF, 8'hFF, 5);
    hold(4'hE, 8'hA4, 1200);
    hold(4'hD, 8'hA4, 1200);
    hold(4'hD, 8'hB0, 1200);
    hold(4'hB, 8'hB0, 1200);
    hold(4'h7, 8'h99, 1200);
    hold(4'hF, 8'hFF, 20);
    check("recap_frames", frames, 6);
    check("recap_hex", {hex3, hex2, hex1, hex0}, 32'h4322);
    check("recap_err_cleared", err, 0);
    check("recap_blank", blank_mask, 0);

    // Scanning stopped: stale after exactly TMO cycles from the last commit.
    stale_cyc = -1;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk_100mhz);
      if (stale) begin
        stale_cyc = cyc;
        break;
      end
    end
    check("stale_latency", stale_cyc - last_stb_cyc, TMO);
    scan_1234(1200);
    check("restart_frames", frames, 7);
    check("restart_stale", stale, 0);
    check("restart_hex", {hex3, hex2, hex1, hex0}, 32'h4321);

    // Reset after three captures discards them.
    hold(4'hE, 8'hF9, 1200);
    hold(4'hD, 8'hA4, 1200);
    hold(4'hB, 8'hB0, 1200);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    an = 4'hF;
    seg = 8'hFF;
    repeat (3) @(negedge clk_100mhz);
    rst_n = 1'b1;
    hold(4'h7, 8'h99, 1200);
    hold(4'hF, 8'hFF, 20);
    check("midrst_no_frame", frames, 7);
    hold(4'hE, 8'hF9, 1200);
    hold(4'hD, 8'hA4, 1200);
    hold(4'hB, 8'hB0, 1200);
    hold(4'hF, 8'hFF, 20);
    check("midrst_frame", frames, 8);
    check("midrst_hex", {hex3, hex2, hex1, hex0}, 32'h4321);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 1000: consecutive identical synchronized samples required before a digit is captured (range 2..65535).
REQ-002 Parameter TIMEOUT_CYCLES, default 2_000_000: cycles without a frame commit before stale asserts (range 2..2^24-1).
REQ-003 clk_100mhz  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 an  in  4  multiplexed anode enables, active-low, an[3] = leftmost digit.
REQ-006 seg  in  8  segments, active-low, seg[0..6] = a..g, seg[7] = dp.
REQ-007 hex3, hex2, hex1, hex0  out  4 each  decoded digit values of the last committed frame.
REQ-008 blank_mask  out  4  bit i = 1: digit i was all-segments-off in last frame.
REQ-009 dp_mask  out  4  bit i = 1: dp lit on digit i in last frame.
REQ-010 err  out  1  at least one digit in last frame had an undecodable pattern.
REQ-011 frame_stb  out  1  one-cycle pulse when a new frame commits.
REQ-012 stale  out  1  no frame committed within TIMEOUT_CYCLES.

Function
REQ-013 an and seg shall pass through a 2-flop synchronizer; all logic below uses synchronized values.
REQ-014 A selection is valid only when exactly one an bit is 0; zero or multiple low bits are "no selection".
REQ-015 FSM states: WAIT_SEL, SETTLE, HOLD.
REQ-016 WAIT_SEL -> SETTLE on a valid selection; stable counter loads 1.
REQ-017 SETTLE: counter increments while {an,seg} equal the previous cycle; any change reloads 1 (new valid selection) or -> WAIT_SEL (no selection).
REQ-018 SETTLE -> HOLD when counter reaches STABLE_CYCLES; in that cycle the digit is captured into a shadow slot and its seen bit set.
REQ-019 HOLD: no further capture; any change of an -> SETTLE (valid) or WAIT_SEL; seg changes alone are ignored.
REQ-020 Decode map (seg[6:0]): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F; 7F->blank (hex 0, blank bit 1); anything else -> hex 0, slot error bit 1.
REQ-021 Recapture of an already-seen digit overwrites its shadow slot.
REQ-022 When all four seen bits are set after a capture, the next edge copies shadow to outputs, asserts frame_stb for exactly that one cycle, clears seen bits and slot error bits, and clears stale.
REQ-023 err = OR of the four slot error bits at commit time.
REQ-024 Timeout counter clears on commit, otherwise increments saturating; stale = 1 when it reaches TIMEOUT_CYCLES.
REQ-025 Input latency: change on pins to capture = 2 + STABLE_CYCLES cycles; capture of fourth digit to frame_stb = 1 cycle.

Reset
REQ-026 rst_n low asynchronously forces: FSM WAIT_SEL, counters 0, seen 0, shadow 0, synchronizers to 1 (idle high), hex3..hex0 = 0, blank_mask = 4'hF, dp_mask = 0, err = 0, frame_stb = 0, stale = 0.
REQ-027 Reset mid-SETTLE or mid-frame discards partial capture; first frame after release requires four fresh captures.

Structure
REQ-028 Segment encoding constants (16 digit codes, blank code) live in the shared seg7 package used by the display driver.
REQ-029 One sub-module, seg7_decode: combinational 7-bit pattern -> {hex, blank, invalid}.

Verification
REQ-030 Scan digits 1,2,3,4 (an E,D,B,7; seg F9,A4,B0,99) each held 2000 cycles, STABLE_CYCLES=1000 -> one frame_stb; hex3..0 = 4,3,2,1; err=0.
REQ-031 Glitch: an=E with seg toggling every 500 cycles -> no capture, no frame_stb.
REQ-032 an=4'h0 (all low) held 5000 cycles -> no capture; FSM stays WAIT_SEL.
REQ-033 Digit 2 pattern 8'hFF, digit 0 dp lit (7F), one pattern 8'hAA -> blank_mask[2]=1, dp_mask[0]=1, err=1.
REQ-034 TIMEOUT_CYCLES=10000, scanning stopped -> stale=1 at cycle 10000; restart scan -> stale=0 with next frame_stb.
REQ-035 Assert rst_n low after three captures -> outputs at reset values immediately; next frame needs four new captures.
